// File: rtl/mem_level_dbus.sv
// MEM pipeline stage driving a req/ready data bus with store lane steering and load extension.
// Optional MEM_ALIGN_EXC_EN: misaligned accesses skip the bus and raise align_exc_o.
`ifndef WIDTH_INSTR
`define WIDTH_INSTR 32
`endif

module mem_level_dbus #(
    parameter int unsigned WIDTH_T = 2,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    stall_i,
    input  logic                    clr_i,
    input  logic [`WIDTH_INSTR-1:0] instr_mem_i,
    input  logic [31:0]             pc_mem_i,
    input  logic [31:0]             alu_out_mem_i,
    input  logic [31:0]             mem_write_data_mem_i,
    input  logic [4:0]              addr_rt_mem_i,
    input  logic [4:0]              reg_write_addr_mem_i,
    input  logic [31:0]             reg_write_data_mem_i,
    input  logic [WIDTH_T-1:0]      tnew_mem_i,
    input  logic [4:0]              regaddr_wb_i,
    input  logic [31:0]             regdata_wb_i,
    output logic                    dbus_req_o,
    output logic                    dbus_we_o,
    output logic [31:0]             dbus_addr_o,
    output logic [3:0]              dbus_be_o,
    output logic [31:0]             dbus_wdata_o,
    input  logic                    dbus_ready_i,
    input  logic [31:0]             dbus_rdata_i,
    output logic                    mem_stall_o,
    output logic [4:0]              regaddr_mem_o,
    output logic [31:0]             regdata_mem_o,
`ifdef MEM_ALIGN_EXC_EN
    output logic                    align_exc_o,
`endif
    output logic [`WIDTH_INSTR-1:0] instr_wb_o,
    output logic [31:0]             pc_wb_o,
    output logic [4:0]              reg_write_addr_wb_o,
    output logic [31:0]             reg_write_data_wb_o,
    output logic [WIDTH_T-1:0]      tnew_wb_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    localparam logic [5:0] OpLb  = 6'b100000;
    localparam logic [5:0] OpLh  = 6'b100001;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpLbu = 6'b100100;
    localparam logic [5:0] OpLhu = 6'b100101;
    localparam logic [5:0] OpSb  = 6'b101000;
    localparam logic [5:0] OpSh  = 6'b101001;
    localparam logic [5:0] OpSw  = 6'b101011;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    logic [5:0]  opcode;
    logic [1:0]  a;
    logic        is_load, is_store, is_mem, misalign, latch_req, load_wb;
    logic [31:0] st_data, st_wdata, load_val, wb_data;
    logic [3:0]  st_be;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [4:0]  wb_addr;
    logic [WIDTH_T-1:0] tnew_d;

    assign opcode = instr_mem_i[31:26];
    assign a      = alu_out_mem_i[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        case (opcode)
            OpLb, OpLbu: is_load = 1'b1;
            OpLh, OpLhu: begin is_load = 1'b1; misalign = a[0]; end
            OpLw:        begin is_load = 1'b1; misalign = (a != 2'b00); end
            OpSb:        is_store = 1'b1;
            OpSh:        begin is_store = 1'b1; misalign = a[0]; end
            OpSw:        begin is_store = 1'b1; misalign = (a != 2'b00); end
            default:     ;
        endcase
        is_mem = is_load | is_store;
    end

    // Store data may still be in flight in WB; bypass it here.
    assign st_data = (regaddr_wb_i == addr_rt_mem_i && regaddr_wb_i != 5'd0) ?
                     regdata_wb_i : mem_write_data_mem_i;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (opcode)
            OpSh: begin
                st_be    = a[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            OpSb: begin
                st_be    = 4'b0001 << a;
                st_wdata = {4{st_data[7:0]}};
            end
            OpSw:    ;
            default: st_wdata = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        latch_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_mem) begin
`ifdef MEM_ALIGN_EXC_EN
                    if (misalign) begin
                        state_d = StDone;
                        rdata_d = '0;
                    end else begin
                        state_d   = StReq;
                        latch_req = 1'b1;
                    end
`else
                    state_d   = StReq;
                    latch_req = 1'b1;
`endif
                end
            end
            StReq: begin
                cnt_d = '0;
                if (dbus_ready_i) begin
                    rdata_d = dbus_rdata_i;
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dbus_ready_i) begin
                    rdata_d = dbus_rdata_i;
                    state_d = StDone;
                end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                if (!stall_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (latch_req) begin
                addr_q  <= {alu_out_mem_i[31:2], 2'b00};
                we_q    <= is_store;
                be_q    <= st_be;
                wdata_q <= st_wdata;
            end
        end
    end

`ifdef MEM_ALIGN_EXC_EN
    logic exc_q, exc_d;

    always_comb begin
        exc_d = exc_q;
        if (state_q == StIdle && is_mem) exc_d = misalign;
        else if (state_q == StDone && !stall_i) exc_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) exc_q <= 1'b0;
        else       exc_q <= exc_d;
    end

    assign align_exc_o = exc_q && (state_q == StDone);
    assign wb_addr     = exc_q ? 5'd0 : reg_write_addr_mem_i;
`else
    assign wb_addr = reg_write_addr_mem_i;
`endif

    assign dbus_req_o   = (state_q == StReq) || (state_q == StWait);
    assign dbus_we_o    = we_q;
    assign dbus_addr_o  = addr_q;
    assign dbus_be_o    = be_q;
    assign dbus_wdata_o = wdata_q;
    assign mem_stall_o  = is_mem && (state_q != StDone);

    assign regaddr_mem_o = (tnew_mem_i != '0) ? 5'd0 : reg_write_addr_mem_i;
    assign regdata_mem_o = reg_write_data_mem_i;

    always_comb begin
        case (a)
            2'd0:    sel_byte = rdata_q[7:0];
            2'd1:    sel_byte = rdata_q[15:8];
            2'd2:    sel_byte = rdata_q[23:16];
            default: sel_byte = rdata_q[31:24];
        endcase
        sel_half = a[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (opcode)
            OpLb:    load_val = {{24{sel_byte[7]}}, sel_byte};
            OpLbu:   load_val = {24'b0, sel_byte};
            OpLh:    load_val = {{16{sel_half[15]}}, sel_half};
            OpLhu:   load_val = {16'b0, sel_half};
            default: load_val = rdata_q;
        endcase
        wb_data = is_load ? load_val : reg_write_data_mem_i;
    end

    assign tnew_d  = (tnew_mem_i >= WIDTH_T'(1)) ? tnew_mem_i - WIDTH_T'(1) : '0;
    assign load_wb = !stall_i && (is_mem ? (state_q == StDone) : 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_wb_o          <= '0;
            pc_wb_o             <= '0;
            reg_write_addr_wb_o <= '0;
            reg_write_data_wb_o <= '0;
            tnew_wb_o           <= '0;
        end else if (clr_i) begin
            instr_wb_o          <= '0;
            pc_wb_o             <= '0;
            reg_write_addr_wb_o <= '0;
            reg_write_data_wb_o <= '0;
            tnew_wb_o           <= '0;
        end else if (load_wb) begin
            instr_wb_o          <= instr_mem_i;
            pc_wb_o             <= pc_mem_i;
            reg_write_addr_wb_o <= wb_addr;
            reg_write_data_wb_o <= wb_data;
            tnew_wb_o           <= tnew_d;
        end
    end

endmodule

// File: tb/tb_mem_level_dbus.sv
// Directed, table-driven bench for mem_level_dbus with a simple ready-delay bus slave.
module tb_mem_level_dbus;

    logic        clk = 1'b0;
    logic        rst, stall, clr;
    logic [31:0] instr, pc, alu, mwd, rwd, rdwb;
    logic [4:0]  rt, rwa, rawb;
    logic [1:0]  tnew;
    logic        req, we, ready, mstall;
    logic [31:0] daddr, wdata, rdata, fd;
    logic [3:0]  be;
    logic [4:0]  fa, a_wb;
    logic [31:0] i_wb, pc_wb, d_wb;
    logic [1:0]  t_wb;
    logic        align_exc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_level_dbus dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .stall_i             (stall),
        .clr_i               (clr),
        .instr_mem_i         (instr),
        .pc_mem_i            (pc),
        .alu_out_mem_i       (alu),
        .mem_write_data_mem_i(mwd),
        .addr_rt_mem_i       (rt),
        .reg_write_addr_mem_i(rwa),
        .reg_write_data_mem_i(rwd),
        .tnew_mem_i          (tnew),
        .regaddr_wb_i        (rawb),
        .regdata_wb_i        (rdwb),
        .dbus_req_o          (req),
        .dbus_we_o           (we),
        .dbus_addr_o         (daddr),
        .dbus_be_o           (be),
        .dbus_wdata_o        (wdata),
        .dbus_ready_i        (ready),
        .dbus_rdata_i        (rdata),
        .mem_stall_o         (mstall),
        .regaddr_mem_o       (fa),
        .regdata_mem_o       (fd),
`ifdef MEM_ALIGN_EXC_EN
        .align_exc_o         (align_exc),
`endif
        .instr_wb_o          (i_wb),
        .pc_wb_o             (pc_wb),
        .reg_write_addr_wb_o (a_wb),
        .reg_write_data_wb_o (d_wb),
        .tnew_wb_o           (t_wb)
    );

`ifndef MEM_ALIGN_EXC_EN
    assign align_exc = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 5'd0, 5'd3, 16'd0};
    endfunction

    // Called just after a rising edge; returns just after the edge that loads WB.
    task automatic run_mem(input logic [31:0] ins, input logic [31:0] ad, input logic [31:0] wd,
                           input logic [4:0] rt_i, input logic [31:0] rd, input int delay,
                           input int clr_at, output logic [3:0] o_be, output logic [31:0] o_wd,
                           output logic [31:0] o_ad, output logic o_we, output int reqs,
                           output int stalls, output bit stable, output bit done,
                           output logic exc);
        instr = ins; alu = ad; mwd = wd; rt = rt_i; rdata = rd; ready = 1'b0;
        reqs = 0; stalls = 0; stable = 1'b1; done = 1'b0; exc = 1'b0;
        o_be = '0; o_wd = '0; o_ad = '0; o_we = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mstall) stalls++;
            if (req) begin
                if (reqs == 0) begin
                    o_be = be; o_wd = wdata; o_ad = daddr; o_we = we;
                end else if (be !== o_be || wdata !== o_wd || daddr !== o_ad || we !== o_we) begin
                    stable = 1'b0;
                end
                reqs++;
                ready = (reqs > delay);
                clr   = (reqs == clr_at);
            end else if (!mstall) begin
                done = 1'b1;
                exc  = align_exc;
            end
            @(posedge clk);
            #1;
            ready = 1'b0;
            clr   = 1'b0;
        end
        instr = 32'h0;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          store;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_wb;
    } vec_t;

    localparam int NV = 12;
    vec_t vt[NV];

    logic [3:0]  o_be;
    logic [31:0] o_wd, o_ad;
    logic        o_we, o_exc;
    int          reqs, stalls;
    bit          stable, done;

    initial begin
        vt[0]  = '{mk(6'b100011), 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'h0, 32'h0, 32'hDEADBEEF};
        vt[1]  = '{mk(6'b100000), 32'h103, 32'h0, 32'h80FFFFFF, 0, 4'h0, 32'h0, 32'hFFFFFF80};
        vt[2]  = '{mk(6'b100100), 32'h103, 32'h0, 32'h80FFFFFF, 0, 4'h0, 32'h0, 32'h00000080};
        vt[3]  = '{mk(6'b100001), 32'h102, 32'h0, 32'h80017FFF, 0, 4'h0, 32'h0, 32'hFFFF8001};
        vt[4]  = '{mk(6'b100101), 32'h102, 32'h0, 32'h80017FFF, 0, 4'h0, 32'h0, 32'h00008001};
        vt[5]  = '{mk(6'b100001), 32'h100, 32'h0, 32'h80017FFF, 0, 4'h0, 32'h0, 32'h00007FFF};
        vt[6]  = '{mk(6'b100000), 32'h101, 32'h0, 32'h0000F200, 0, 4'h0, 32'h0, 32'hFFFFFFF2};
        vt[7]  = '{mk(6'b101011), 32'h200, 32'h11223344, 32'h0, 1, 4'hF, 32'h11223344, 32'h55555555};
        vt[8]  = '{mk(6'b101001), 32'h202, 32'h1234ABCD, 32'h0, 1, 4'hC, 32'hABCDABCD, 32'h55555555};
        vt[9]  = '{mk(6'b101001), 32'h200, 32'h1234ABCD, 32'h0, 1, 4'h3, 32'hABCDABCD, 32'h55555555};
        vt[10] = '{mk(6'b101000), 32'h201, 32'h000000A5, 32'h0, 1, 4'h2, 32'hA5A5A5A5, 32'h55555555};
        vt[11] = '{mk(6'b101000), 32'h203, 32'h000000A5, 32'h0, 1, 4'h8, 32'hA5A5A5A5, 32'h55555555};

        rst = 1'b1; stall = 1'b0; clr = 1'b0; instr = '0; pc = '0; alu = '0; mwd = '0;
        rwd = '0; rdwb = '0; rt = '0; rwa = '0; rawb = '0; tnew = '0; ready = 1'b0; rdata = '0;
        #12;
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_memstall", {31'b0, mstall}, 32'h0);
        chk("rst_addr", daddr, 32'h0);
        chk("rst_be_wdata", {28'b0, be} | wdata, 32'h0);
        chk("rst_wb_data", d_wb, 32'h0);
        chk("rst_wb_instr", i_wb, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            rwd = 32'h55555555; rwa = 5'd7; pc = 32'h400 + 32'(i * 4);
            run_mem(vt[i].ins, vt[i].ad, vt[i].wd, 5'd3, vt[i].rd, 0, -1,
                    o_be, o_wd, o_ad, o_we, reqs, stalls, stable, done, o_exc);
            chk($sformatf("v%0d_done", i), {31'b0, done}, 32'h1);
            chk($sformatf("v%0d_addr", i), o_ad, vt[i].ad & 32'hFFFFFFFC);
            chk($sformatf("v%0d_we", i), {31'b0, o_we}, {31'b0, vt[i].store});
            if (vt[i].store) begin
                chk($sformatf("v%0d_be", i), {28'b0, o_be}, {28'b0, vt[i].exp_be});
                chk($sformatf("v%0d_wdata", i), o_wd, vt[i].exp_wd);
            end
            chk($sformatf("v%0d_wb_data", i), d_wb, vt[i].exp_wb);
            chk($sformatf("v%0d_wb_addr", i), {27'b0, a_wb}, 32'd7);
            chk($sformatf("v%0d_wb_pc", i), pc_wb, 32'h400 + 32'(i * 4));
        end

        // LW with ready on the first request cycle
        run_mem(mk(6'b100011), 32'h100, 32'h0, 5'd3, 32'hDEADBEEF, 0, -1,
                o_be, o_wd, o_ad, o_we, reqs, stalls, stable, done, o_exc);
        chk("lw_req_cycles", 32'(reqs), 32'd1);
        chk("lw_stall_cycles", 32'(stalls), 32'd2);
        chk("lw_wb", d_wb, 32'hDEADBEEF);

        // SH with ready delayed 4 cycles
        run_mem(mk(6'b101001), 32'h202, 32'h1234ABCD, 5'd3, 32'h0, 4, -1,
                o_be, o_wd, o_ad, o_we, reqs, stalls, stable, done, o_exc);
        chk("sh_req_cycles", 32'(reqs), 32'd5);
        chk("sh_stable", {31'b0, stable}, 32'h1);
        chk("sh_be", {28'b0, o_be}, 32'hC);
        chk("sh_wdata", o_wd, 32'hABCDABCD);
        chk("sh_stall_cycles", 32'(stalls), 32'd6);

        // Store-data bypass from WB
        rawb = 5'd5; rdwb = 32'h77;
        run_mem(mk(6'b101011), 32'h300, 32'h1, 5'd5, 32'h0, 0, -1,
                o_be, o_wd, o_ad, o_we, reqs, stalls, stable, done, o_exc);
        chk("fwd_hit", o_wd, 32'h77);
        rawb = 5'd0;
        run_mem(mk(6'b101011), 32'h300, 32'h1, 5'd5, 32'h0, 0, -1,
                o_be, o_wd, o_ad, o_we, reqs, stalls, stable, done, o_exc);
        chk("fwd_r0", o_wd, 32'h1);
        rdwb = 32'h0;

        // clr while waiting must not lose the load
        run_mem(mk(6'b100011), 32'h140, 32'h0, 5'd3, 32'hCAFEF00D, 4, 2,
                o_be, o_wd, o_ad, o_we, reqs, stalls, stable, done, o_exc);
        chk("clr_wait_done", {31'b0, done}, 32'h1);
        chk("clr_wait_wb", d_wb, 32'hCAFEF00D);

        // Non-memory instruction: forward pair, Tnew, stall and clr
        instr = 32'h00000020; rwd = 32'h1234; rwa = 5'd9; tnew = 2'd2; pc = 32'h500;
        #1;
        chk("alu_memstall", {31'b0, mstall}, 32'h0);
        chk("alu_fwd_addr_busy", {27'b0, fa}, 32'h0);
        chk("alu_fwd_data", fd, 32'h1234);
        @(posedge clk); #1;
        chk("alu_wb_data", d_wb, 32'h1234);
        chk("alu_wb_tnew", {30'b0, t_wb}, 32'd1);
        tnew = 2'd0; #1;
        chk("alu_fwd_addr", {27'b0, fa}, 32'd9);
        @(posedge clk); #1;
        chk("alu_wb_tnew0", {30'b0, t_wb}, 32'd0);
        tnew = 2'd3; stall = 1'b1; rwd = 32'hBEEF;
        @(posedge clk); #1;
        chk("stall_hold", d_wb, 32'h1234);
        stall = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_zero", d_wb, 32'h0);
        chk("clr_zero_addr", {27'b0, a_wb}, 32'h0);
        clr = 1'b0;
        @(posedge clk); #1;
        chk("after_clr", d_wb, 32'hBEEF);
        chk("after_clr_tnew", {30'b0, t_wb}, 32'd2);

`ifdef MEM_ALIGN_EXC_EN
        rwa = 5'd7;
        run_mem(mk(6'b100011), 32'h101, 32'h0, 5'd3, 32'h0, 0, -1,
                o_be, o_wd, o_ad, o_we, reqs, stalls, stable, done, o_exc);
        chk("exc_no_req", 32'(reqs), 32'd0);
        chk("exc_flag", {31'b0, o_exc}, 32'h1);
        chk("exc_wb_addr", {27'b0, a_wb}, 32'h0);
`endif

        // Asynchronous reset while waiting for the bus
        instr = mk(6'b100011); alu = 32'h180; ready = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                seen = req;
            end
            chk("rstw_req_seen", {31'b0, seen}, 32'h1);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstw_req_drop", {31'b0, req}, 32'h0);
        chk("rstw_wb_data", d_wb, 32'h0);
        chk("rstw_wb_instr", i_wb, 32'h0);
        chk("rstw_wb_pc", pc_wb, 32'h0);
        instr = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
